// File: rtl/rob_multiport_if.sv
// Reorder-buffer port bundle: dispatch, CDB broadcast, operand lookup, retire and recovery.
// Handshake: an entry is accepted when alloc_valid and alloc_ready are both high at a clock edge.
interface rob_multiport_if #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int NUM_CDB = 2
);
  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [3:0]                alloc_op;
  logic [2:0]                alloc_dest;
  logic [DATA_W-1:0]         alloc_value;
  logic                      alloc_done;
  logic [15:0]               alloc_pc;
  logic                      alloc_predict;
  logic [3:0]                alloc_bht;
  logic [TAG_W-1:0]          alloc_tag;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]          rd_tag1;
  logic [TAG_W-1:0]          rd_tag2;
  logic [DATA_W-1:0]         rd_value1;
  logic [DATA_W-1:0]         rd_value2;
  logic                      rd_done1;
  logic                      rd_done2;
  logic                      head_valid;
  logic [TAG_W-1:0]          head_tag;
  logic [3:0]                head_op;
  logic [2:0]                head_dest;
  logic [DATA_W-1:0]         head_value;
  logic [15:0]               head_pc;
  logic                      head_predict;
  logic [3:0]                head_bht;
  logic                      commit;
  logic                      squash_valid;
  logic [TAG_W-1:0]          squash_tag;
  logic                      flush;
  logic [TAG_W:0]            count;
  logic                      empty;
  logic                      full;

  modport master (
    output alloc_valid, alloc_op, alloc_dest, alloc_value, alloc_done, alloc_pc,
           alloc_predict, alloc_bht, cdb_valid, cdb_tag, cdb_data, rd_tag1, rd_tag2,
           commit, squash_valid, squash_tag, flush,
    input  alloc_ready, alloc_tag, rd_value1, rd_value2, rd_done1, rd_done2,
           head_valid, head_tag, head_op, head_dest, head_value, head_pc,
           head_predict, head_bht, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_dest, alloc_value, alloc_done, alloc_pc,
           alloc_predict, alloc_bht, cdb_valid, cdb_tag, cdb_data, rd_tag1, rd_tag2,
           commit, squash_valid, squash_tag, flush,
    output alloc_ready, alloc_tag, rd_value1, rd_value2, rd_done1, rd_done2,
           head_valid, head_tag, head_op, head_dest, head_value, head_pc,
           head_predict, head_bht, count, empty, full
  );
endinterface

// File: rtl/rob_multiport.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB completion, in-order commit,
// with combinational CDB bypass on lookup, partial squash and full flush.
module rob_multiport #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = $clog2(DEPTH),
  parameter int NUM_CDB = 2
) (
  input logic            clk,
  input logic            rst_n,
  rob_multiport_if.slave bus
);
  localparam int PTR_W = TAG_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d;
  logic [DEPTH-1:0]  kill, cdb_hit;
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] value_d [DEPTH];
  logic [DATA_W-1:0] cdb_val [DEPTH];
  logic [3:0]        op_q    [DEPTH];
  logic [2:0]        dest_q  [DEPTH];
  logic [15:0]       pc_q    [DEPTH];
  logic [3:0]        bht_q   [DEPTH];
  logic [DEPTH-1:0]  pred_q;

  logic [TAG_W-1:0]  head_idx, tail_idx, sq_off;
  logic [PTR_W-1:0]  count;
  logic              full, head_valid, squash_apply, alloc_fire, commit_fire;

  always_comb begin
    head_idx     = head_q[TAG_W-1:0];
    tail_idx     = tail_q[TAG_W-1:0];
    count        = tail_q - head_q;
    full         = (count == PTR_W'(DEPTH));
    head_valid   = busy_q[head_idx] & done_q[head_idx];
    squash_apply = bus.squash_valid & busy_q[bus.squash_tag];
    sq_off       = bus.squash_tag - head_idx;
    alloc_fire   = bus.alloc_valid & ~full & ~squash_apply;
    commit_fire  = bus.commit & head_valid;
  end

  // Per-entry CDB match (lowest channel wins) and squash kill by age relative to head.
  always_comb begin
    cdb_hit = '0;
    kill    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cdb_val[i] = '0;
      kill[i]    = squash_apply && ((TAG_W'(i) - head_idx) > sq_off);
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (bus.cdb_valid[c] && (bus.cdb_tag[c*TAG_W +: TAG_W] == TAG_W'(i))) begin
          cdb_hit[i] = 1'b1;
          cdb_val[i] = bus.cdb_data[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    busy_d = busy_q;
    done_d = done_q;
    for (int i = 0; i < DEPTH; i++) value_d[i] = value_q[i];
    if (bus.flush) begin
      head_d = '0;
      tail_d = '0;
      busy_d = '0;
      done_d = '0;
    end else begin
      if (squash_apply)    tail_d = head_q + PTR_W'(sq_off) + PTR_W'(1);
      else if (alloc_fire) tail_d = tail_q + PTR_W'(1);
      if (commit_fire)     head_d = head_q + PTR_W'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) begin
          busy_d[i] = 1'b0;
          done_d[i] = 1'b0;
        end else if (busy_q[i] && cdb_hit[i]) begin
          done_d[i]  = 1'b1;
          value_d[i] = cdb_val[i];
        end
      end
      if (commit_fire) begin
        busy_d[head_idx] = 1'b0;
        done_d[head_idx] = 1'b0;
      end
      // Allocation is applied last so it overrides any CDB write to the same slot.
      if (alloc_fire) begin
        busy_d[tail_idx]  = 1'b1;
        done_d[tail_idx]  = bus.alloc_done;
        value_d[tail_idx] = bus.alloc_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) value_q[i] <= value_d[i];
    if (alloc_fire && !bus.flush) begin
      op_q[tail_idx]   <= bus.alloc_op;
      dest_q[tail_idx] <= bus.alloc_dest;
      pc_q[tail_idx]   <= bus.alloc_pc;
      pred_q[tail_idx] <= bus.alloc_predict;
      bht_q[tail_idx]  <= bus.alloc_bht;
    end
  end

  always_comb begin
    bus.rd_value1 = value_q[bus.rd_tag1];
    bus.rd_done1  = busy_q[bus.rd_tag1] & done_q[bus.rd_tag1];
    bus.rd_value2 = value_q[bus.rd_tag2];
    bus.rd_done2  = busy_q[bus.rd_tag2] & done_q[bus.rd_tag2];
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (bus.cdb_valid[c] && (bus.cdb_tag[c*TAG_W +: TAG_W] == bus.rd_tag1)) begin
        bus.rd_value1 = bus.cdb_data[c*DATA_W +: DATA_W];
        bus.rd_done1  = 1'b1;
      end
      if (bus.cdb_valid[c] && (bus.cdb_tag[c*TAG_W +: TAG_W] == bus.rd_tag2)) begin
        bus.rd_value2 = bus.cdb_data[c*DATA_W +: DATA_W];
        bus.rd_done2  = 1'b1;
      end
    end
  end

  assign bus.alloc_ready  = ~full;
  assign bus.alloc_tag    = tail_idx;
  assign bus.head_valid   = head_valid;
  assign bus.head_tag     = head_idx;
  assign bus.head_op      = op_q[head_idx];
  assign bus.head_dest    = dest_q[head_idx];
  assign bus.head_value   = value_q[head_idx];
  assign bus.head_pc      = pc_q[head_idx];
  assign bus.head_predict = pred_q[head_idx];
  assign bus.head_bht     = bht_q[head_idx];
  assign bus.count        = count;
  assign bus.empty        = (count == '0);
  assign bus.full         = full;

endmodule

// File: tb/tb_rob_multiport.sv
// Self-checking bench for rob_multiport: directed scenarios plus randomized traffic
// compared against a queue-based model of the reorder buffer.
module tb_rob_multiport;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 8;
  localparam int TAG_W   = 3;
  localparam int NUM_CDB = 2;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  rob_multiport_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) bus ();

  rob_multiport #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: oldest entry at index 0
  typedef struct {
    int          tag;
    bit          done;
    logic [15:0] value;
    logic [3:0]  op;
    logic [2:0]  dest;
    logic [15:0] pc;
    logic        pred;
    logic [3:0]  bht;
  } ent_t;

  ent_t              m_q[$];
  int                m_head;
  logic [DATA_W-1:0] exp_q[$];

  task automatic model_step();
    int          size_pre, tail_tag, sq_pos;
    bit          can_commit, full_pre, hit;
    logic [15:0] commit_val;
    ent_t        e;
    if (!rst_n || bus.flush) begin
      m_q.delete();
      m_head = 0;
      return;
    end
    size_pre   = m_q.size();
    full_pre   = (size_pre == DEPTH);
    can_commit = bus.commit && size_pre > 0 && m_q[0].done;
    commit_val = (size_pre > 0) ? m_q[0].value : '0;
    tail_tag   = (m_head + size_pre) % DEPTH;
    sq_pos     = -1;
    if (bus.squash_valid)
      foreach (m_q[k]) if (m_q[k].tag == int'(bus.squash_tag)) sq_pos = k;
    if (sq_pos >= 0)
      while (m_q.size() > sq_pos + 1) void'(m_q.pop_back());
    foreach (m_q[k]) begin
      hit = 1'b0;
      for (int c = 0; c < NUM_CDB; c++) begin
        if (!hit && bus.cdb_valid[c] && int'(bus.cdb_tag[c*TAG_W +: TAG_W]) == m_q[k].tag) begin
          hit           = 1'b1;
          m_q[k].done  = 1'b1;
          m_q[k].value = bus.cdb_data[c*DATA_W +: DATA_W];
        end
      end
    end
    if (can_commit) begin
      exp_q.push_back(commit_val);
      void'(m_q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (bus.alloc_valid && !full_pre && sq_pos < 0) begin
      e.tag   = tail_tag;
      e.done  = bus.alloc_done;
      e.value = bus.alloc_value;
      e.op    = bus.alloc_op;
      e.dest  = bus.alloc_dest;
      e.pc    = bus.alloc_pc;
      e.pred  = bus.alloc_predict;
      e.bht   = bus.alloc_bht;
      m_q.push_back(e);
    end
  endtask

  function automatic void ref_lookup(input logic [TAG_W-1:0] tg, output bit d,
                                     output logic [DATA_W-1:0] v);
    d = 1'b0;
    v = '0;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (!d && bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == tg) begin
        d = 1'b1;
        v = bus.cdb_data[c*DATA_W +: DATA_W];
      end
    end
    if (!d)
      foreach (m_q[k])
        if (m_q[k].tag == int'(tg) && m_q[k].done) begin
          d = 1'b1;
          v = m_q[k].value;
        end
  endfunction

  // driver tasks
  task automatic idle_inputs();
    bus.alloc_valid   = 1'b0;
    bus.alloc_op      = '0;
    bus.alloc_dest    = '0;
    bus.alloc_value   = '0;
    bus.alloc_done    = 1'b0;
    bus.alloc_pc      = '0;
    bus.alloc_predict = 1'b0;
    bus.alloc_bht     = '0;
    bus.cdb_valid     = '0;
    bus.cdb_tag       = '0;
    bus.cdb_data      = '0;
    bus.rd_tag1       = '0;
    bus.rd_tag2       = '0;
    bus.commit        = 1'b0;
    bus.squash_valid  = 1'b0;
    bus.squash_tag    = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic alloc_one(input bit done, input logic [15:0] val);
    idle_inputs();
    bus.alloc_valid = 1'b1;
    bus.alloc_done  = done;
    bus.alloc_value = val;
    bus.alloc_op    = val[3:0];
    bus.alloc_pc    = val ^ 16'h3000;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++;
    if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++;
    if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.alloc_ready); end
    checks++;
    if (bus.head_valid !== 1'b0) begin errors++; $display("FAIL reset_head_valid got=%b exp=0", bus.head_valid); end
    checks++;
    if (bus.alloc_tag !== 3'd0) begin errors++; $display("FAIL reset_alloc_tag got=%0d exp=0", bus.alloc_tag); end
    checks++;
    if (bus.head_tag !== 3'd0) begin errors++; $display("FAIL reset_head_tag got=%0d exp=0", bus.head_tag); end
    checks++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.alloc_tag !== 3'(i)) begin errors++; $display("FAIL fill_tag got=%0d exp=%0d", bus.alloc_tag, i); end
      checks++;
      alloc_one(1'b0, 16'(16'h0100 + i));
    end
    if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", bus.full); end
    checks++;
    if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", bus.alloc_ready); end
    checks++;
    alloc_one(1'b1, 16'h9999);
    if (bus.count !== 4'd8) begin errors++; $display("FAIL fill_overflow_count got=%0d exp=8", bus.count); end
    checks++;
    idle_inputs();
  endtask

  task automatic test_cdb_priority();
    idle_inputs();
    bus.cdb_valid = 2'b11;
    bus.cdb_tag   = {3'd3, 3'd3};
    bus.cdb_data  = {16'hBEEF, 16'h1234};
    bus.rd_tag1   = 3'd3;
    #1;
    if (bus.rd_value1 !== 16'h1234) begin errors++; $display("FAIL bypass_value got=%h exp=1234", bus.rd_value1); end
    checks++;
    if (bus.rd_done1 !== 1'b1) begin errors++; $display("FAIL bypass_done got=%b exp=1", bus.rd_done1); end
    checks++;
    step();
    idle_inputs();
    bus.rd_tag1 = 3'd3;
    bus.rd_tag2 = 3'd2;
    #1;
    if (bus.rd_value1 !== 16'h1234) begin errors++; $display("FAIL cdb_prio_stored got=%h exp=1234", bus.rd_value1); end
    checks++;
    if (bus.rd_done1 !== 1'b1) begin errors++; $display("FAIL cdb_prio_done got=%b exp=1", bus.rd_done1); end
    checks++;
    if (bus.rd_done2 !== 1'b0) begin errors++; $display("FAIL pending_done got=%b exp=0", bus.rd_done2); end
    checks++;
  endtask

  task automatic test_ooo_commit();
    idle_inputs();
    bus.cdb_valid = 2'b01;
    bus.cdb_tag   = {3'd0, 3'd1};
    bus.cdb_data  = {16'h0000, 16'h1111};
    bus.commit    = 1'b1;
    step();
    idle_inputs();
    bus.commit = 1'b1;
    step();
    if (bus.head_tag !== 3'd0) begin errors++; $display("FAIL ooo_hold_tag got=%0d exp=0", bus.head_tag); end
    checks++;
    if (bus.head_valid !== 1'b0) begin errors++; $display("FAIL ooo_hold_valid got=%b exp=0", bus.head_valid); end
    checks++;
    bus.cdb_valid = 2'b01;
    bus.cdb_tag   = {3'd0, 3'd0};
    bus.cdb_data  = {16'h0000, 16'h0A0A};
    step();
    bus.cdb_valid = '0;
    if (bus.head_tag !== 3'd0 || bus.head_valid !== 1'b1 || bus.head_value !== 16'h0A0A) begin
      errors++;
      $display("FAIL ooo_head0 got tag=%0d v=%b val=%h exp tag=0 v=1 val=0a0a", bus.head_tag, bus.head_valid, bus.head_value);
    end
    checks++;
    step();
    if (bus.head_tag !== 3'd1 || bus.head_value !== 16'h1111) begin
      errors++; $display("FAIL ooo_head1 got tag=%0d val=%h exp tag=1 val=1111", bus.head_tag, bus.head_value);
    end
    checks++;
    step();
    if (bus.head_tag !== 3'd2 || bus.head_valid !== 1'b0) begin
      errors++; $display("FAIL ooo_head2 got tag=%0d v=%b exp tag=2 v=0", bus.head_tag, bus.head_valid);
    end
    checks++;
    if (bus.count !== 4'd6) begin errors++; $display("FAIL ooo_count got=%0d exp=6", bus.count); end
    checks++;
    idle_inputs();
  endtask

  task automatic test_flush();
    alloc_one(1'b1, 16'h2000);
    alloc_one(1'b1, 16'h2001);
    if (bus.full !== 1'b1) begin errors++; $display("FAIL flush_prefull got=%b exp=1", bus.full); end
    checks++;
    idle_inputs();
    bus.flush        = 1'b1;
    bus.commit       = 1'b1;
    bus.alloc_valid  = 1'b1;
    bus.squash_valid = 1'b1;
    bus.squash_tag   = 3'd4;
    bus.cdb_valid    = 2'b01;
    bus.cdb_tag      = {3'd0, 3'd5};
    step();
    idle_inputs();
    if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL flush_count got=%0d empty=%b exp 0/1", bus.count, bus.empty);
    end
    checks++;
    if (bus.head_tag !== 3'd0 || bus.alloc_tag !== 3'd0) begin
      errors++; $display("FAIL flush_ptrs got head=%0d tail=%0d exp 0/0", bus.head_tag, bus.alloc_tag);
    end
    checks++;
    if (bus.head_valid !== 1'b0) begin errors++; $display("FAIL flush_head_valid got=%b exp=0", bus.head_valid); end
    checks++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) alloc_one(1'b1, 16'(16'h0500 + i));
    idle_inputs();
    bus.commit = 1'b1;
    for (int i = 0; i < 6; i++) step();
    idle_inputs();
    if (bus.head_tag !== 3'd6 || bus.count !== 4'd0) begin
      errors++; $display("FAIL wrap_drain got head=%0d count=%0d exp 6/0", bus.head_tag, bus.count);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      if (bus.alloc_tag !== 3'((6 + i) % DEPTH)) begin
        errors++; $display("FAIL wrap_tag got=%0d exp=%0d", bus.alloc_tag, (6 + i) % DEPTH);
      end
      checks++;
      alloc_one(1'b0, 16'(16'h0600 + i));
    end
    if (bus.count !== 4'd5 || bus.full !== 1'b0) begin
      errors++; $display("FAIL wrap_count got count=%0d full=%b exp 5/0", bus.count, bus.full);
    end
    checks++;
    idle_inputs();
  endtask

  task automatic test_squash();
    do_reset();
    for (int i = 0; i < 6; i++) alloc_one(1'b0, 16'(16'h0700 + i));
    idle_inputs();
    bus.squash_valid = 1'b1;
    bus.squash_tag   = 3'd2;
    bus.alloc_valid  = 1'b1;
    step();
    if (bus.count !== 4'd3 || bus.alloc_tag !== 3'd3) begin
      errors++; $display("FAIL squash_tail got count=%0d tag=%0d exp 3/3", bus.count, bus.alloc_tag);
    end
    checks++;
    idle_inputs();
    bus.cdb_valid = 2'b01;
    bus.cdb_tag   = {3'd0, 3'd4};
    bus.cdb_data  = {16'h0000, 16'h4444};
    step();
    idle_inputs();
    bus.rd_tag1 = 3'd4;
    #1;
    if (bus.rd_done1 !== 1'b0) begin errors++; $display("FAIL squash_dead_tag got=%b exp=0", bus.rd_done1); end
    checks++;
    bus.squash_valid = 1'b1;
    bus.squash_tag   = 3'd6;
    step();
    idle_inputs();
    if (bus.count !== 4'd3) begin errors++; $display("FAIL squash_ignored got=%0d exp=3", bus.count); end
    checks++;
  endtask

  task automatic test_random(input int n);
    bit                ed1, ed2, eh, got_c;
    logic [DATA_W-1:0] ev1, ev2, got_v, want;
    int                tg;
    do_reset();
    exp_q.delete();
    for (int t = 0; t < n; t++) begin
      bus.alloc_valid   = ($urandom_range(0, 9) < 7);
      bus.alloc_done    = ($urandom_range(0, 3) == 0);
      bus.alloc_value   = 16'($urandom);
      bus.alloc_op      = 4'($urandom);
      bus.alloc_dest    = 3'($urandom);
      bus.alloc_pc      = 16'($urandom);
      bus.alloc_predict = 1'($urandom);
      bus.alloc_bht     = 4'($urandom);
      for (int c = 0; c < NUM_CDB; c++) begin
        bus.cdb_valid[c] = ($urandom_range(0, 2) != 0);
        if (m_q.size() > 0 && $urandom_range(0, 3) != 0) tg = m_q[$urandom_range(0, m_q.size() - 1)].tag;
        else tg = $urandom_range(0, DEPTH - 1);
        bus.cdb_tag[c*TAG_W +: TAG_W]   = TAG_W'(tg);
        bus.cdb_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      bus.commit       = ($urandom_range(0, 9) < 6);
      bus.squash_valid = ($urandom_range(0, 29) == 0);
      bus.squash_tag   = 3'($urandom);
      bus.flush        = ($urandom_range(0, 99) == 0);
      rst_n            = ($urandom_range(0, 199) != 0);
      bus.rd_tag1      = 3'($urandom);
      bus.rd_tag2      = 3'($urandom);
      #2;
      ref_lookup(bus.rd_tag1, ed1, ev1);
      ref_lookup(bus.rd_tag2, ed2, ev2);
      if (bus.rd_done1 !== ed1 || (ed1 && bus.rd_value1 !== ev1)) begin
        errors++; $display("FAIL rnd_lookup1 t=%0d got d=%b v=%h exp d=%b v=%h", t, bus.rd_done1, bus.rd_value1, ed1, ev1);
      end
      checks++;
      if (bus.rd_done2 !== ed2 || (ed2 && bus.rd_value2 !== ev2)) begin
        errors++; $display("FAIL rnd_lookup2 t=%0d got d=%b v=%h exp d=%b v=%h", t, bus.rd_done2, bus.rd_value2, ed2, ev2);
      end
      checks++;
      got_c = bus.commit && bus.head_valid && rst_n && !bus.flush;
      got_v = bus.head_value;
      step();
      if (bus.count !== 4'(m_q.size()) || bus.empty !== (m_q.size() == 0) ||
          bus.full !== (m_q.size() == DEPTH) || bus.alloc_ready !== (m_q.size() != DEPTH)) begin
        errors++; $display("FAIL rnd_occupancy t=%0d got count=%0d exp=%0d", t, bus.count, m_q.size());
      end
      checks++;
      if (bus.head_tag !== 3'(m_head) || bus.alloc_tag !== 3'((m_head + m_q.size()) % DEPTH)) begin
        errors++; $display("FAIL rnd_ptrs t=%0d got head=%0d tail=%0d exp head=%0d", t, bus.head_tag, bus.alloc_tag, m_head);
      end
      checks++;
      eh = (m_q.size() > 0) && m_q[0].done;
      if (bus.head_valid !== eh) begin
        errors++; $display("FAIL rnd_head_valid t=%0d got=%b exp=%b", t, bus.head_valid, eh);
      end
      checks++;
      if (eh) begin
        if (bus.head_value !== m_q[0].value || bus.head_op !== m_q[0].op || bus.head_dest !== m_q[0].dest ||
            bus.head_pc !== m_q[0].pc || bus.head_predict !== m_q[0].pred || bus.head_bht !== m_q[0].bht) begin
          errors++; $display("FAIL rnd_head_fields t=%0d got val=%h pc=%h exp val=%h pc=%h", t, bus.head_value, bus.head_pc, m_q[0].value, m_q[0].pc);
        end
        checks++;
      end
      if (got_c) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : ~got_v;
        if (got_v !== want) begin
          errors++; $display("FAIL rnd_commit t=%0d got=%h exp=%h", t, got_v, want);
        end
        checks++;
      end
      if (exp_q.size() != 0) begin
        errors++; $display("FAIL rnd_commit_missing t=%0d got=none exp=%h", t, exp_q[0]);
        exp_q.delete();
        checks++;
      end
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    rst_n  = 1'b0;
    m_head = 0;
    idle_inputs();
    test_reset();
    test_fill();
    test_cdb_priority();
    test_ooo_commit();
    test_flush();
    test_wrap();
    test_squash();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
